peripheral_biu_arbiter: RTL and testbench

- Two-master to one-slave BIU arbiter. It sits directly upstream of the SPRAM BIU bridge and lets the instruction-side BIU (m0) and the data-side BIU (m1) share one BIU slave port.
- Arbitration is round-robin. A grant is held until every beat of every accepted burst has been acknowledged, and it is extended while the granted master holds lock.
- Burst-type encodings come from peripheral_biu_pkg (HBURST_*).

---
 rtl/peripheral_biu_arbiter_if.sv | 30 +++
 rtl/peripheral_biu_arbiter.sv | 118 +++++++++++
 tb/tb_peripheral_biu_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_biu_arbiter_if.sv
// rtl/peripheral_biu_arbiter_if.sv - BIU link between one master and one slave
interface peripheral_biu_arbiter_if #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
);
  logic            stb;
  logic            stb_ack;
  logic            d_ack;
  logic [PLEN-1:0] adri;
  logic [PLEN-1:0] adro;
  logic [2:0]      size;
  logic [2:0]      btype;
  logic [2:0]      prot;
  logic            lock;
  logic            we;
  logic [XLEN-1:0] d;
  logic [XLEN-1:0] q;
  logic            ack;
  logic            err;

  modport master (
    output stb, adri, size, btype, prot, lock, we, d,
    input  stb_ack, d_ack, adro, q, ack, err
  );

  modport slave (
    input  stb, adri, size, btype, prot, lock, we, d,
    output stb_ack, d_ack, adro, q, ack, err
  );
endinterface

// File: rtl/peripheral_biu_arbiter.sv
// rtl/peripheral_biu_arbiter.sv - round-robin two-master to one-slave BIU arbiter
package peripheral_biu_pkg;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;
endpackage

module peripheral_biu_arbiter
  import peripheral_biu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  peripheral_biu_arbiter_if.slave  m0,
  peripheral_biu_arbiter_if.slave  m1,
  peripheral_biu_arbiter_if.master s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_last;
  logic [5:0] r_outst;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_accept;
  logic [6:0] w_beats;
  logic [6:0] w_sum;
  logic [5:0] w_outst_nxt;
  logic       w_cur_lock;
  logic       w_release;

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);

  // Request path: m0 is the default source so IDLE shows m0's address/data.
  assign s.stb   = (w_gnt0 & m0.stb) | (w_gnt1 & m1.stb);
  assign s.adri  = w_gnt1 ? m1.adri  : m0.adri;
  assign s.size  = w_gnt1 ? m1.size  : m0.size;
  assign s.btype = w_gnt1 ? m1.btype : m0.btype;
  assign s.prot  = w_gnt1 ? m1.prot  : m0.prot;
  assign s.lock  = w_gnt1 ? m1.lock  : m0.lock;
  assign s.we    = w_gnt1 ? m1.we    : m0.we;
  assign s.d     = w_gnt1 ? m1.d     : m0.d;

  assign m0.stb_ack = w_gnt0 & s.stb_ack;
  assign m0.d_ack   = w_gnt0 & s.d_ack;
  assign m0.ack     = w_gnt0 & s.ack;
  assign m0.err     = w_gnt0 & s.err;
  assign m1.stb_ack = w_gnt1 & s.stb_ack;
  assign m1.d_ack   = w_gnt1 & s.d_ack;
  assign m1.ack     = w_gnt1 & s.ack;
  assign m1.err     = w_gnt1 & s.err;

  assign m0.q    = s.q;
  assign m1.q    = s.q;
  assign m0.adro = s.adro;
  assign m1.adro = s.adro;

  always_comb begin
    w_beats = 7'd1;
    case (s.btype)
      HBURST_WRAP4,  HBURST_INCR4:  w_beats = 7'd4;
      HBURST_WRAP8,  HBURST_INCR8:  w_beats = 7'd8;
      HBURST_WRAP16, HBURST_INCR16: w_beats = 7'd16;
      default:                      w_beats = 7'd1;
    endcase
  end

  assign w_accept = s.stb & s.stb_ack;

  always_comb begin
    w_sum = {1'b0, r_outst} + (w_accept ? w_beats : 7'd0);
    if (s.ack && (w_sum != 7'd0)) w_sum = w_sum - 7'd1;
    if (s.err)                    w_outst_nxt = 6'd0;
    else if (w_sum > 7'd63)       w_outst_nxt = 6'd63;
    else                          w_outst_nxt = w_sum[5:0];
  end

  assign w_cur_lock = w_gnt1 ? m1.lock : m0.lock;
  // A strobe accepted on the draining cycle keeps the grant for its beats.
  assign w_release  = (w_outst_nxt == 6'd0) & ~w_accept & ~w_cur_lock;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_outst <= 6'd0;
    end else begin
      r_outst <= w_outst_nxt;
      case (r_state)
        IDLE: begin
          if (m0.stb && (!m1.stb || r_last)) begin
            r_state <= GNT0;
            r_last  <= 1'b0;
          end else if (m1.stb) begin
            r_state <= GNT1;
            r_last  <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (w_release) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_biu_arbiter.sv
// tb/tb_peripheral_biu_arbiter.sv - directed self-checking bench for peripheral_biu_arbiter
module tb_peripheral_biu_arbiter;
  import peripheral_biu_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  peripheral_biu_arbiter_if #(.XLEN(64), .PLEN(64)) m0_if ();
  peripheral_biu_arbiter_if #(.XLEN(64), .PLEN(64)) m1_if ();
  peripheral_biu_arbiter_if #(.XLEN(64), .PLEN(64)) s_if ();

  peripheral_biu_arbiter dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Granted master 'who' has its strobe up: accept it, then return n acks.
  task automatic burst(input int who, input int n);
    s_if.stb_ack = 1'b1;
    #1;
    check("burst_fwd", s_if.stb, 1);
    tick;
    check("burst_load", dut.r_outst, n);
    s_if.stb_ack = 1'b0;
    if (who == 0) m0_if.stb = 1'b0;
    else          m1_if.stb = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_if.ack = 1'b1;
      tick;
      check("burst_cnt", dut.r_outst, n - 1 - i);
    end
    s_if.ack = 1'b0;
    check("burst_idle", dut.r_state, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    m0_if.stb = 0; m0_if.adri = 0; m0_if.size = 3'd3; m0_if.btype = HBURST_SINGLE;
    m0_if.prot = 0; m0_if.lock = 0; m0_if.we = 0; m0_if.d = 0;
    m1_if.stb = 0; m1_if.adri = 0; m1_if.size = 3'd3; m1_if.btype = HBURST_SINGLE;
    m1_if.prot = 0; m1_if.lock = 0; m1_if.we = 0; m1_if.d = 0;
    s_if.stb_ack = 0; s_if.d_ack = 0; s_if.ack = 0; s_if.err = 0;
    s_if.adro = 64'h0; s_if.q = 64'h0;
    tick; tick;
    check("rst_state", dut.r_state, 0);
    check("rst_outst", dut.r_outst, 0);
    check("rst_last", dut.r_last, 1);
    check("rst_sstb", s_if.stb, 0);
    rst = 1'b1;
    tick;

    // m0 single read, m1 idle
    m0_if.stb = 1; m0_if.adri = 64'h100; m0_if.btype = HBURST_SINGLE;
    #1;
    check("s1_idle_nofwd", s_if.stb, 0);
    tick;
    check("s1_gnt0", dut.r_state, 1);
    s_if.stb_ack = 1;
    #1;
    check("s1_sstb", s_if.stb, 1);
    check("s1_adri", s_if.adri, 64'h100);
    check("s1_m0_stbak", m0_if.stb_ack, 1);
    check("s1_m1_stbak", m1_if.stb_ack, 0);
    tick;
    check("s1_outst1", dut.r_outst, 1);
    m0_if.stb = 0; s_if.stb_ack = 0; s_if.ack = 1; s_if.q = 64'hdead;
    #1;
    check("s1_m0_ack", m0_if.ack, 1);
    check("s1_m1_ack", m1_if.ack, 0);
    check("s1_m0_q", m0_if.q, 64'hdead);
    tick;
    s_if.ack = 0;
    check("s1_outst0", dut.r_outst, 0);
    check("s1_idle", dut.r_state, 0);

    // simultaneous strobes after reset: m0 INCR4 first, then m1, then tie to m0
    rst = 0; tick; rst = 1; tick;
    m0_if.stb = 1; m0_if.btype = HBURST_INCR4;
    m1_if.stb = 1; m1_if.btype = HBURST_SINGLE;
    tick;
    check("s2_gnt0", dut.r_state, 1);
    #1;
    check("s2_type", s_if.btype, HBURST_INCR4);
    burst(0, 4);
    check("s2_idle_nofwd", s_if.stb, 0);
    tick;
    check("s2_gnt1", dut.r_state, 2);
    burst(1, 1);
    m0_if.stb = 1; m0_if.btype = HBURST_SINGLE; m1_if.stb = 1;
    tick;
    check("s2_tie_m0", dut.r_state, 1);
    m1_if.stb = 0;
    burst(0, 1);

    // m1 WRAP8 write
    m1_if.stb = 1; m1_if.we = 1; m1_if.btype = HBURST_WRAP8; m1_if.d = 64'h55;
    tick;
    check("s3_gnt1", dut.r_state, 2);
    s_if.d_ack = 1;
    #1;
    check("s3_we", s_if.we, 1);
    check("s3_d", s_if.d, 64'h55);
    check("s3_m1_dack", m1_if.d_ack, 1);
    check("s3_m0_dack", m0_if.d_ack, 0);
    s_if.stb_ack = 1;
    tick;
    check("s3_load8", dut.r_outst, 8);
    s_if.stb_ack = 0; s_if.d_ack = 0; m1_if.stb = 0; m1_if.we = 0;
    for (int i = 0; i < 8; i++) begin
      s_if.ack = 1;
      #1;
      check("s3_sstb_low", s_if.stb, 0);
      tick;
      check("s3_cnt", dut.r_outst, 7 - i);
      check("s3_state", dut.r_state, (i == 7) ? 0 : 2);
    end
    s_if.ack = 0;

    // locked m0 with two singles; m1 pending
    m0_if.stb = 1; m0_if.lock = 1; m0_if.btype = HBURST_SINGLE;
    m1_if.stb = 1; m1_if.btype = HBURST_SINGLE;
    tick;
    check("s4_gnt0", dut.r_state, 1);
    s_if.stb_ack = 1;
    #1;
    check("s4_m1_stbak", m1_if.stb_ack, 0);
    tick;
    m0_if.stb = 0; s_if.stb_ack = 0; s_if.ack = 1;
    tick;
    s_if.ack = 0;
    check("s4_held_out0", dut.r_outst, 0);
    check("s4_held", dut.r_state, 1);
    tick;
    check("s4_held_gap", dut.r_state, 1);
    check("s4_gap_sstb", s_if.stb, 0);
    m0_if.stb = 1; s_if.stb_ack = 1;
    #1;
    check("s4_second_fwd", s_if.stb, 1);
    check("s4_second_m0ak", m0_if.stb_ack, 1);
    tick;
    m0_if.stb = 0; m0_if.lock = 0; s_if.stb_ack = 0; s_if.ack = 1;
    tick;
    s_if.ack = 0;
    check("s4_release", dut.r_state, 0);
    tick;
    check("s4_gnt1", dut.r_state, 2);
    burst(1, 1);

    // error on the 2nd beat of an INCR16
    m0_if.stb = 1; m0_if.btype = HBURST_INCR16; m1_if.stb = 1;
    tick;
    check("s5_gnt0", dut.r_state, 1);
    s_if.stb_ack = 1;
    tick;
    check("s5_load16", dut.r_outst, 16);
    s_if.stb_ack = 0; m0_if.stb = 0; s_if.ack = 1;
    tick;
    check("s5_out15", dut.r_outst, 15);
    s_if.ack = 0; s_if.err = 1;
    #1;
    check("s5_m0_err", m0_if.err, 1);
    check("s5_m1_err", m1_if.err, 0);
    tick;
    s_if.err = 0;
    check("s5_clear", dut.r_outst, 0);
    check("s5_idle", dut.r_state, 0);
    #1;
    check("s5_err_pulse", m0_if.err, 0);
    tick;
    check("s5_gnt1", dut.r_state, 2);
    burst(1, 1);

    // asynchronous reset with 5 beats outstanding on m1
    m1_if.stb = 1; m1_if.btype = HBURST_INCR8;
    tick;
    check("s6_gnt1", dut.r_state, 2);
    s_if.stb_ack = 1;
    tick;
    s_if.stb_ack = 0; m1_if.stb = 0;
    for (int i = 0; i < 3; i++) begin
      s_if.ack = 1;
      tick;
    end
    s_if.ack = 0;
    check("s6_out5", dut.r_outst, 5);
    m1_if.stb = 1;
    #1;
    check("s6_fwd", s_if.stb, 1);
    #2;
    rst = 0;
    #1;
    check("s6_rst_state", dut.r_state, 0);
    check("s6_rst_outst", dut.r_outst, 0);
    check("s6_rst_sstb", s_if.stb, 0);
    m0_if.stb = 1; m0_if.btype = HBURST_INCR16;
    #1;
    rst = 1;
    tick;
    check("s6_tie_m0", dut.r_state, 1);

    // back-to-back INCR16 accepts saturate the beat count
    s_if.stb_ack = 1;
    for (int i = 0; i < 4; i++) tick;
    check("sat_63", dut.r_outst, 63);
    check("sat_held", dut.r_state, 1);
    s_if.stb_ack = 0; m0_if.stb = 0; m1_if.stb = 0;
    rst = 0; tick; rst = 1; tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
